multi_ch_clk_gen: RTL

Parametrised multi-channel clock/tick generator. It replaces the fixed 1 Hz / 10 Hz / 400 Hz divider modules with one block. NUM_CH independent channels each divide clk by a runtime-programmable half-period. Each channel drives a 50%-duty square wave and a one-cycle tick pulse per period. It feeds the clock display, alarm logic and 7-segment multiplexing; a shared sync input phase-aligns all channels.

---
 rtl/multi_ch_clk_gen_if.sv | 42 ++++
 rtl/multi_ch_clk_gen.sv | 97 +++++++++
 2 files changed

// File: rtl/multi_ch_clk_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : multi_ch_clk_gen_if
//  Brief    : Control/status bundle for the multi-channel clock generator.
//             The master side owns enables, sync and the half-period write
//             port. The slave side returns the per-channel square waves and
//             tick pulses.
//  Revision : 1.0  initial release
// ============================================================================
interface multi_ch_clk_gen_if #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 27
);
    logic [NUM_CH-1:0] ch_en;
    logic              sync;
    logic              div_we;
    logic [2:0]        div_sel;
    logic [CNT_W-1:0]  div_data;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick_out;

    modport master (
        output ch_en,
        output sync,
        output div_we,
        output div_sel,
        output div_data,
        input  clk_out,
        input  tick_out
    );

    modport slave (
        input  ch_en,
        input  sync,
        input  div_we,
        input  div_sel,
        input  div_data,
        output clk_out,
        output tick_out
    );
endinterface
`default_nettype wire

// File: rtl/multi_ch_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : multi_ch_clk_gen
//  Brief    : NUM_CH independent clock dividers. Each channel produces a
//             50%-duty square wave with a runtime-programmable half-period
//             and a one-cycle tick after every rising edge of that wave.
//             A shared sync input restarts every channel in phase.
//  Revision : 1.0  initial release
// ============================================================================
module multi_ch_clk_gen #(
    parameter int NUM_CH       = 3,
    parameter int CNT_W        = 27,
    parameter int DEFAULT_HALF = 50_000_000
) (
    input  wire logic          clk,
    input  wire logic          resetSW,
    multi_ch_clk_gen_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_default_half = CNT_W'(DEFAULT_HALF);
    localparam logic [CNT_W-1:0] c_one          = CNT_W'(1);

    // A programmed half-period of zero would never wrap; clamp it to one.
    logic [CNT_W-1:0]  w_wdata;
    logic [NUM_CH-1:0] w_clk_out;
    logic [NUM_CH-1:0] w_tick_out;

    assign w_wdata = (bus.div_data == '0) ? c_one : bus.div_data;

    generate
        for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] r_half;
            logic [CNT_W-1:0] r_shadow;
            logic [CNT_W-1:0] w_shadow_nxt;
            logic             r_clk;
            logic             r_tick;
            logic             w_sel;
            logic             w_wrap;
            logic             w_idle;

            // Selector values at or above NUM_CH never match any channel.
            assign w_sel        = bus.div_we && (bus.div_sel == 3'(ch));
            // The value the shadow holds after this edge. Every H reload
            // uses it, so a write that lands on a wrap, sync or idle cycle
            // takes effect immediately rather than one period late.
            assign w_shadow_nxt = w_sel ? w_wdata : r_shadow;
            // H is always at least one, so H-1 never underflows.
            assign w_wrap       = (r_cnt == r_half - c_one);
            // Sync and disable share one restart path. Sync wins over
            // counting regardless of the enable.
            assign w_idle       = bus.sync || !bus.ch_en[ch];

            // Shadow half-period: capture writes addressed to this channel.
            always_ff @(posedge clk or negedge resetSW) begin
                if (!resetSW) begin
                    r_shadow <= c_default_half;
                end else begin
                    r_shadow <= w_shadow_nxt;
                end
            end

            // Divider: count to H-1, toggle the output and reload H at wrap.
            // Restart from phase zero while idle or on sync.
            always_ff @(posedge clk or negedge resetSW) begin
                if (!resetSW) begin
                    r_cnt  <= '0;
                    r_half <= c_default_half;
                    r_clk  <= 1'b0;
                    r_tick <= 1'b0;
                end else if (w_idle) begin
                    r_cnt  <= '0;
                    r_half <= w_shadow_nxt;
                    r_clk  <= 1'b0;
                    r_tick <= 1'b0;
                end else if (w_wrap) begin
                    r_cnt  <= '0;
                    r_half <= w_shadow_nxt;
                    r_clk  <= ~r_clk;
                    // The tick fires only on the low-to-high transition.
                    r_tick <= ~r_clk;
                end else begin
                    r_cnt  <= r_cnt + c_one;
                    r_tick <= 1'b0;
                end
            end

            assign w_clk_out[ch]  = r_clk;
            assign w_tick_out[ch] = r_tick;
        end
    endgenerate

    assign bus.clk_out  = w_clk_out;
    assign bus.tick_out = w_tick_out;

endmodule
`default_nettype wire
